peak_tracker: RTL and testbench
===============================

Name: peak_tracker

Overview:
- Frame-based running-maximum tracker that sits directly around the 4-bit magnitude comparator.
- Upstream role: drives each incoming sample and the current maximum onto the comparator operand inputs.
- Downstream role: consumes the comparator's greater/less/equal flags in the same cycle to update its state.
- Input is a valid/ready sample stream delimited by a last flag. Per frame it reports the maximum value, its index, the tie count and the frame length.

Parameters:
- CNT_W, 8, width of the index, tie and length counters; all saturate at 2^CNT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  4  sample value, unsigned.
- in_last  in  1  sample is the final one of its frame.
- cmp_a  out  4  comparator operand A; always equals in_data.
- cmp_b  out  4  comparator operand B; always equals max_q.
- cmp_la  in  1  A>B.
- cmp_lb  in  1  B>A.
- cmp_s  in  1  A=B.
- out_valid  out  1  frame result valid.
- out_ready  in  1  result consumer ready.
- out_max  out  4  frame maximum.
- out_idx  out  CNT_W  index of the first occurrence of the maximum (0-based).
- out_ties  out  CNT_W  number of later samples equal to the maximum.
- out_len  out  CNT_W  number of samples in the frame.

Behaviour:
- Reset (async assert, sync release): state=IDLE; max_q, idx_q, ties_q, len_q = 0; out_valid=0; all out_* = 0.
- Accept condition: in_valid & in_ready at the rising edge.
- cmp_a and cmp_b are purely combinational. The comparator flags are sampled in the same cycle; there are no pipeline registers on that path.
- States:
  - IDLE: no frame open. in_ready=1. Accept → first sample of the frame: max_q=in_data, idx_q=0, ties_q=0, len_q=1. Comparator flags are ignored. Next state is ACC, or HOLD if in_last=1.
  - ACC: frame open. in_ready=1. Accept → update by flag priority la > s > lb:
    - la: max_q=in_data, idx_q=len_q, ties_q=0.
    - s (and not la): ties_q+1, saturating.
    - lb only, or no flag: no max/idx/ties change.
    - len_q+1, saturating, on every accept.
    - in_last=1 → HOLD.
  - HOLD: in_ready=0. Output registers are loaded with the frame results on the cycle HOLD is entered, so out_valid=1 on the first cycle in HOLD. Results are inclusive of the last sample. Outputs stay stable until out_valid & out_ready; then the next state is IDLE.
- Latency: the last sample is accepted at edge N; out_valid=1 after edge N. A new frame can start at the edge following the handshake (one-cycle bubble in IDLE).
- Single-sample frame (in_last on the first sample): out_max=in_data, idx=0, ties=0, len=1.
- Saturation:
  - len_q holds at all-ones; subsequent samples are still compared.
  - A new max after saturation records idx_q = all-ones.
  - ties_q holds at all-ones.
- in_valid while in HOLD: not accepted; the upstream must hold its data.
- out_* are registers, never combinational from the inputs.
- Reset mid-frame or mid-HOLD: immediate return to reset values; the partial frame is discarded and no result is emitted.

Optional Feature:
- Macro PEAK_TRACKER_ONEHOT_CHECK_EN.
- Defined:
  - Adds output port cmp_err (1 bit, reset 0).
  - cmp_err sets and stays set (cleared only by reset) when an accepted non-first sample sees {cmp_la,cmp_lb,cmp_s} not exactly one-hot.
  - Datapath behaviour is unchanged (priority la > s > lb still applies).
- Undefined: cmp_err and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then frame 3,7,2,7,5 (last on 5), out_ready=1, ideal comparator → out_valid one cycle after the last accept; out_max=7, out_idx=1, out_ties=1, out_len=5; back to IDLE the cycle after the handshake.
- Single sample 9 with in_last, out_ready=0 for 4 cycles → out_valid held 4+ cycles, in_ready=0 throughout, outputs 9/0/0/1 stable; released when out_ready=1.
- Frame of all 4'hF, 300 samples, CNT_W=8 → out_len=255, out_ties=255, out_idx=0, out_max=F.
- Assert rst_n low mid-frame after samples 1,2, then send frame 4 (last) → result 4/0/0/1; no stale output from the aborted frame.
- Frame 0,0,1 → first 0 loads; second 0 via s: ties=1; 1 via la: max=1, idx=2, ties=0, len=3.
- With PEAK_TRACKER_ONEHOT_CHECK_EN: drive cmp_la=cmp_lb=1 on a non-first accept → cmp_err=1 next cycle and sticky; max takes in_data per la priority. Without the macro: same stimulus, same datapath result, no cmp_err port.

Source files
------------

// File: rtl/peak_tracker.sv
// Frame-based running-maximum tracker wrapped around an external 4-bit magnitude comparator.
// Optional sticky comparator sanity flag (cmp_err) enabled by PEAK_TRACKER_ONEHOT_CHECK_EN.
module peak_tracker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic             in_last,
    output logic [3:0]       cmp_a,
    output logic [3:0]       cmp_b,
    input  logic             cmp_la,
    input  logic             cmp_lb,
    input  logic             cmp_s,
`ifdef PEAK_TRACKER_ONEHOT_CHECK_EN
    output logic             cmp_err,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_max,
    output logic [CNT_W-1:0] out_idx,
    output logic [CNT_W-1:0] out_ties,
    output logic [CNT_W-1:0] out_len
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q;
    logic [3:0]       max_q;
    logic [CNT_W-1:0] idx_q, ties_q, len_q;

    logic             accept;
    logic [3:0]       max_d;
    logic [CNT_W-1:0] idx_d, ties_d, len_d;

    assign in_ready = (state_q != HOLD);
    assign accept   = in_valid & in_ready;
    assign cmp_a    = in_data;
    assign cmp_b    = max_q;

    // Next frame statistics if the presented sample is accepted this cycle.
    always_comb begin
        max_d  = max_q;
        idx_d  = idx_q;
        ties_d = ties_q;
        len_d  = len_q;
        if (state_q == IDLE) begin
            max_d  = in_data;
            idx_d  = '0;
            ties_d = '0;
            len_d  = CNT_ONE;
        end else begin
            if (cmp_la) begin
                max_d  = in_data;
                idx_d  = len_q;
                ties_d = '0;
            end else if (cmp_s) begin
                if (ties_q != CNT_MAX)
                    ties_d = ties_q + CNT_ONE;
            end
            if (len_q != CNT_MAX)
                len_d = len_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            max_q     <= '0;
            idx_q     <= '0;
            ties_q    <= '0;
            len_q     <= '0;
            out_valid <= 1'b0;
            out_max   <= '0;
            out_idx   <= '0;
            out_ties  <= '0;
            out_len   <= '0;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    if (accept) begin
                        max_q  <= max_d;
                        idx_q  <= idx_d;
                        ties_q <= ties_d;
                        len_q  <= len_d;
                        if (in_last) begin
                            state_q   <= HOLD;
                            out_valid <= 1'b1;
                            out_max   <= max_d;
                            out_idx   <= idx_d;
                            out_ties  <= ties_d;
                            out_len   <= len_d;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q   <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef PEAK_TRACKER_ONEHOT_CHECK_EN
    logic onehot;
    assign onehot = ({cmp_la, cmp_lb, cmp_s} == 3'b100) ||
                    ({cmp_la, cmp_lb, cmp_s} == 3'b010) ||
                    ({cmp_la, cmp_lb, cmp_s} == 3'b001);

    // Only non-first samples consult the comparator, so only those are checked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cmp_err <= 1'b0;
        else if (accept && (state_q == ACC) && !onehot)
            cmp_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_peak_tracker.sv
`timescale 1ns/1ps
module tb_peak_tracker;

  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic             in_last;
  logic [3:0]       cmp_a, cmp_b;
  logic             cmp_la, cmp_lb, cmp_s;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_max;
  logic [CNT_W-1:0] out_idx, out_ties, out_len;
`ifdef PEAK_TRACKER_ONEHOT_CHECK_EN
  logic             cmp_err;
`endif

  logic       ovr;
  logic [2:0] ov_flags;
  assign cmp_la = ovr ? ov_flags[2] : (cmp_a > cmp_b);
  assign cmp_lb = ovr ? ov_flags[1] : (cmp_a < cmp_b);
  assign cmp_s  = ovr ? ov_flags[0] : (cmp_a == cmp_b);

  peak_tracker #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_la    (cmp_la),
    .cmp_lb    (cmp_lb),
    .cmp_s     (cmp_s),
`ifdef PEAK_TRACKER_ONEHOT_CHECK_EN
    .cmp_err   (cmp_err),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .out_ties  (out_ties),
    .out_len   (out_len)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  function automatic int run_max();
    int m = 0;
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  task automatic model(output int mx, output int idx, output int ties, output int len);
    int cnt = 0;
    mx  = run_max();
    idx = -1;
    foreach (q[i]) begin
      if (q[i] == mx) begin
        if (idx < 0) idx = i;
        cnt++;
      end
    end
    idx  = sat(idx);
    ties = sat(cnt - 1);
    len  = sat(q.size());
  endtask

  task automatic send(input logic [3:0] d, input logic l);
    bit got = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int c = 0; c < 50 && !got; c++) begin
      if (in_ready === 1'b1) begin
        ncmp++;
        if (cmp_a !== d) begin
          nerr++;
          $error("FAIL cmp_a observed=%0h expected=%0h", cmp_a, d);
        end
        if (q.size() > 0 && !ovr) begin
          ncmp++;
          if (cmp_b !== 4'(run_max())) begin
            nerr++;
            $error("FAIL cmp_b observed=%0h expected=%0h", cmp_b, run_max());
          end
        end
        got = 1;
      end
      @(posedge clk); #1;
    end
    if (!got) chk("accept_timeout", in_ready, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    q.push_back(d);
    if (!l) chk("busy_out_valid", out_valid, 1'b0);
  endtask

  task automatic check_fields(input int mx, input int idx, input int ties, input int len, input int hold);
    out_ready = (hold == 0);
    chk("out_valid", out_valid, 1'b1);
    chk("hold_in_ready", in_ready, 1'b0);
    chk("out_max", out_max, mx);
    chk("out_idx", out_idx, idx);
    chk("out_ties", out_ties, ties);
    chk("out_len", out_len, len);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      ncmp += 4;
      if (out_valid !== 1'b1) begin
        nerr++;
        $error("FAIL stall_valid observed=%0h expected=1", out_valid);
      end
      if (in_ready !== 1'b0) begin
        nerr++;
        $error("FAIL stall_in_ready observed=%0h expected=0", in_ready);
      end
      if (out_max !== 4'(mx)) begin
        nerr++;
        $error("FAIL stall_max observed=%0h expected=%0h", out_max, mx);
      end
      if (out_len !== CNT_W'(len)) begin
        nerr++;
        $error("FAIL stall_len observed=%0h expected=%0h", out_len, len);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_valid", out_valid, 1'b0);
    chk("post_in_ready", in_ready, 1'b1);
    q.delete();
  endtask

  task automatic check_model(input int hold);
    int mx, idx, ties, len;
    model(mx, idx, ties, len);
    check_fields(mx, idx, ties, len, hold);
  endtask

  initial begin
    int n;
    int range;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    ovr       = 1'b0;
    ov_flags  = '0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_max", out_max, 4'h0);
    chk("rst_out_len", out_len, 8'h00);
    chk("rst_cmp_b", cmp_b, 4'h0);
`ifdef PEAK_TRACKER_ONEHOT_CHECK_EN
    chk("rst_cmp_err", cmp_err, 1'b0);
`endif

    send(3, 0); send(7, 0); send(2, 0); send(7, 0); send(5, 1);
    check_fields(7, 1, 1, 5, 0);

    send(9, 1);
    check_fields(9, 0, 0, 1, 4);

    for (int i = 0; i < 300; i++) send(4'hF, i == 299);
    check_fields(15, 0, 255, 255, 0);

    for (int i = 0; i < 260; i++) send(4'h0, 0);
    send(4'h5, 1);
    check_fields(5, 255, 0, 255, 0);

    send(1, 0); send(2, 0);
    rst_n = 1'b0;
    #2;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_cmp_b", cmp_b, 4'h0);
    chk("midrst_out_len", out_len, 8'h00);
    #2 rst_n = 1'b1;
    q.delete();
    @(posedge clk); #1;
    chk("after_rst_valid", out_valid, 1'b0);
    send(4, 1);
    check_fields(4, 0, 0, 1, 0);

    send(0, 0); send(0, 0); send(1, 1);
    check_fields(1, 2, 0, 3, 0);

    for (int f = 0; f < 25; f++) begin
      n     = $urandom_range(1, 30);
      range = ($urandom_range(0, 1) == 0) ? 3 : 15;
      for (int i = 0; i < n; i++) send(4'($urandom_range(0, range)), i == n - 1);
`ifdef PEAK_TRACKER_ONEHOT_CHECK_EN
      chk("rand_cmp_err", cmp_err, 1'b0);
`endif
      check_model($urandom_range(0, 3));
    end

    send(5, 0);
    ovr      = 1'b1;
    ov_flags = 3'b110;
    send(2, 1);
    ovr      = 1'b0;
`ifdef PEAK_TRACKER_ONEHOT_CHECK_EN
    chk("cmp_err_set", cmp_err, 1'b1);
`endif
    check_fields(2, 1, 0, 2, 1);
    send(3, 1);
`ifdef PEAK_TRACKER_ONEHOT_CHECK_EN
    chk("cmp_err_sticky", cmp_err, 1'b1);
`endif
    check_fields(3, 0, 0, 1, 0);
    rst_n = 1'b0;
    #2;
`ifdef PEAK_TRACKER_ONEHOT_CHECK_EN
    chk("cmp_err_rst", cmp_err, 1'b0);
`endif
    chk("final_rst_max", cmp_b, 4'h0);
    #2 rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
